// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter and the encoder/decoder bench.
package arb_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = $clog2(N_REQ);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  typedef logic [N_REQ-1:0] req_vec_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         pick_c,
  output logic [$clog2(N)-1:0] idx_c,
  output logic                 any_c
);

  localparam int unsigned PTR_W = $clog2(N);

  logic [2*N-1:0] dbl_req;
  logic [N-1:0]   rot_req;
  logic [N-1:0]   rot_pick;
  logic [2*N-1:0] dbl_pick;
  logic [PTR_W-1:0] ffs_idx;
  logic             found;

  // Rotate right so ptr lands at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    dbl_req  = {req, req} >> ptr;
    rot_req  = dbl_req[N-1:0];
    found    = 1'b0;
    ffs_idx  = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && rot_req[i]) begin
        found   = 1'b1;
        ffs_idx = PTR_W'(i);
      end
    end
    rot_pick = found ? (N'(1) << ffs_idx) : '0;
    dbl_pick = {rot_pick, rot_pick} << ptr;
    pick_c   = dbl_pick[2*N-1:N];
    idx_c    = PTR_W'((32'(ffs_idx) + 32'(ptr)) % N);
    any_c    = found;
  end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with held, one-hot registered grant and a release watchdog.
module rr_onehot_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N       = N_REQ,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         done,
  output logic [N-1:0] grant,
  output logic         grant_vld,
  output logic         busy,
  output logic         timeout_err
);

  localparam int unsigned PTR_W = $clog2(N);
  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] WDOG_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
  localparam bit WDOG_EN = (TIMEOUT != 0);

  arb_state_t       state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] wdog_q, wdog_d;
  logic [N-1:0]     grant_d;
  logic             grant_vld_d;
  logic             busy_d;
  logic             timeout_err_d;

  logic [N-1:0]     pick_c;
  logic [PTR_W-1:0] pick_idx_c;
  logic             pick_any_c;
  logic [PTR_W-1:0] owner_next_c;

  rr_pick #(.N(N)) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .pick_c (pick_c),
    .idx_c  (pick_idx_c),
    .any_c  (pick_any_c)
  );

  // Priority moves just past the released owner, wrapping at N-1.
  assign owner_next_c = (owner_q == PTR_W'(N - 1)) ? '0 : owner_q + PTR_W'(1);

  // State, pointer, watchdog and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      wdog_q      <= '0;
      grant       <= '0;
      grant_vld   <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      wdog_q      <= wdog_d;
      grant       <= grant_d;
      grant_vld   <= grant_vld_d;
      busy        <= busy_d;
      timeout_err <= timeout_err_d;
    end
  end

  // Next-state: arbitrate in IDLE, hold in GRANT until done or watchdog expiry.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    owner_d       = owner_q;
    wdog_d        = wdog_q;
    grant_d       = grant;
    grant_vld_d   = grant_vld;
    busy_d        = busy;
    timeout_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any_c) begin
          state_d     = GRANT;
          grant_d     = pick_c;
          owner_d     = pick_idx_c;
          grant_vld_d = 1'b1;
          busy_d      = 1'b1;
          wdog_d      = '0;
        end
      end
      GRANT: begin
        if (done || (WDOG_EN && (wdog_q == WDOG_LAST))) begin
          state_d       = IDLE;
          grant_d       = '0;
          grant_vld_d   = 1'b0;
          busy_d        = 1'b0;
          ptr_d         = owner_next_c;
          wdog_d        = '0;
          timeout_err_d = !done;
        end else if (WDOG_EN) begin
          wdog_d = wdog_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Grant is never more than one-hot and grant_vld mirrors it.
  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(grant) && (grant_vld == (|grant)));

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Self-checking bench for rr_onehot_arbiter: vector table, corner sequences, random vs model.
module tb_rr_onehot_arbiter;

  localparam int N       = 4;
  localparam int TIMEOUT = 16;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic         done;
  logic [N-1:0] grant;
  logic         grant_vld;
  logic         busy;
  logic         timeout_err;

  int tests;
  int fails;

  // Reference model state: who holds the grant, for how long, and the priority index.
  bit m_busy;
  int m_owner;
  int m_ptr;
  int m_cnt;
  bit m_terr;

  typedef struct packed {
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic       vld;
    logic       busy;
    logic       terr;
  } vec_t;

  vec_t tbl [12];

  rr_onehot_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_vld   (grant_vld),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_ptr   = 0;
    m_cnt   = 0;
    m_terr  = 1'b0;
  endtask

  // One clock of the arbitration rules applied to the inputs seen at the edge.
  task automatic m_step(input logic [N-1:0] r, input logic d);
    bit found;
    m_terr = 1'b0;
    if (!m_busy) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (!found && r[(m_ptr + k) % N]) begin
          found   = 1'b1;
          m_owner = (m_ptr + k) % N;
          m_busy  = 1'b1;
          m_cnt   = 0;
        end
      end
    end else if (d) begin
      m_busy = 1'b0;
      m_ptr  = (m_owner + 1) % N;
    end else if (m_cnt == TIMEOUT - 1) begin
      m_busy = 1'b0;
      m_ptr  = (m_owner + 1) % N;
      m_terr = 1'b1;
    end else begin
      m_cnt++;
    end
  endtask

  // Advance one cycle, update the model, and compare all outputs 1ns after the edge.
  task automatic tick();
    logic [N-1:0] exp_grant;
    @(posedge clk);
    m_step(req, done);
    #1;
    exp_grant = m_busy ? N'(1 << m_owner) : '0;
    chk("model_grant", 32'(grant), 32'(exp_grant));
    chk("model_vld", 32'(grant_vld), 32'(m_busy));
    chk("model_busy", 32'(busy), 32'(m_busy));
    chk("model_terr", 32'(timeout_err), 32'(m_terr));
    chk("onehot0", 32'($onehot0(grant)), 32'(1));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", 32'(grant), 32'(0));
    chk("rst_vld", 32'(grant_vld), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_terr", 32'(timeout_err), 32'(0));
    rst_n = 1'b1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    m_reset();

    // {req, done, grant, vld, busy, terr}
    tbl[0]  = {4'b1010, 1'b0, 4'b0010, 1'b1, 1'b1, 1'b0};
    tbl[1]  = {4'b1010, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0};
    tbl[2]  = {4'b1010, 1'b0, 4'b1000, 1'b1, 1'b1, 1'b0};
    tbl[3]  = {4'b1111, 1'b1, 4'b0001, 1'b1, 1'b1, 1'b0};
    tbl[4]  = {4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0};
    tbl[5]  = {4'b1111, 1'b1, 4'b0010, 1'b1, 1'b1, 1'b0};
    tbl[6]  = {4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0};
    tbl[7]  = {4'b1111, 1'b1, 4'b0100, 1'b1, 1'b1, 1'b0};
    tbl[8]  = {4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0};
    tbl[9]  = {4'b1111, 1'b1, 4'b1000, 1'b1, 1'b1, 1'b0};
    tbl[10] = {4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0};
    tbl[11] = {4'b1111, 1'b1, 4'b0001, 1'b1, 1'b1, 1'b0};

    // Idle with no requests.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_grant", 32'(grant), 32'(0));
      chk("idle_busy", 32'(busy), 32'(0));
    end

    // Vector table; fresh reset before the 1010 run and before the 1111 run.
    for (int i = 0; i < 12; i++) begin
      if (i == 0 || i == 3) do_reset();
      req  = tbl[i].req;
      done = tbl[i].done;
      tick();
      chk("tbl_grant", 32'(grant), 32'(tbl[i].grant));
      chk("tbl_vld", 32'(grant_vld), 32'(tbl[i].vld));
      chk("tbl_busy", 32'(busy), 32'(tbl[i].busy));
      chk("tbl_terr", 32'(timeout_err), 32'(tbl[i].terr));
    end

    // Watchdog expiry: requester 2 drops its request and never signals done.
    do_reset();
    req = 4'b0100;
    tick();
    req = 4'b0000;
    for (int i = 1; i < 16; i++) begin
      tick();
      chk("wd_hold", 32'(grant), 32'(4'b0100));
      chk("wd_noerr", 32'(timeout_err), 32'(0));
    end
    tick();
    chk("wd_release", 32'(grant), 32'(0));
    chk("wd_terr", 32'(timeout_err), 32'(1));
    req = 4'b1111;
    tick();
    chk("wd_terr_pulse", 32'(timeout_err), 32'(0));
    chk("wd_ptr3", 32'(grant), 32'(4'b1000));

    // done coinciding with the last watchdog cycle suppresses timeout_err.
    do_reset();
    req = 4'b0001;
    tick();
    for (int i = 1; i < 16; i++) tick();
    chk("co_hold", 32'(grant), 32'(4'b0001));
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("co_release", 32'(grant), 32'(0));
    chk("co_terr", 32'(timeout_err), 32'(0));

    // Asynchronous reset mid-grant clears grant before any clock edge.
    do_reset();
    req = 4'b1000;
    tick();
    chk("ar_grant", 32'(grant), 32'(4'b1000));
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_async_grant", 32'(grant), 32'(0));
    chk("ar_async_vld", 32'(grant_vld), 32'(0));
    chk("ar_async_busy", 32'(busy), 32'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_reset();
    req = 4'b1000;
    tick();
    chk("ar_regrant", 32'(grant), 32'(4'b1000));

    // Random traffic against the model, with stretches of withheld done.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      req = N'($urandom_range(0, 15));
      if ((i % 300) < 40) done = 1'b0;
      else done = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rr_onehot_arbiter.md
Name: rr_onehot_arbiter

Overview:
- Round-robin arbiter stage directly upstream of the 4-bit priority encoder.
- Arbitrates N request lines and drives a registered grant vector that is always either zero or one-hot. The grant feeds the encoder input i, so the encoder and decoder pair only ever sees legal codes.
- Each grant is held until the owner signals done, or until a watchdog timeout expires.

Parameters:
- N, 4, number of requesters; equals encoder input width.
- TIMEOUT, 16, max cycles a grant may be held without done; 0 disables the watchdog.
- CNT_W, $clog2(TIMEOUT+1), watchdog counter width (derived, not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- req  input  N  request lines; bit k = requester k; level-sensitive.
- done  input  1  owner releases current grant; sampled only in GRANT.
- grant  output  N  registered grant; all-zero or one-hot; drives encoder i.
- grant_vld  output  1  high iff grant != 0.
- busy  output  1  high in GRANT state.
- timeout_err  output  1  one-cycle pulse when the watchdog forces a release.

Interface note: one clock; reset is asynchronous and active-low (clk, rst_n). All outputs are registered.

Behaviour:
- Reset (rst_n=0, asynchronous): grant=0, grant_vld=0, busy=0, timeout_err=0, ptr=0, wdog=0, state=IDLE.
- Reset mid-grant: grant drops to 0 immediately, without waiting for a clock edge.
- ptr (log2 N bits) marks the highest-priority index for the next arbitration.
- State IDLE:
  - req==0: stay in IDLE, grant=0.
  - req!=0: choose the first set bit scanning ptr, ptr+1, ..., wrapping mod N. At the next edge, grant=onehot(winner), grant_vld=1, busy=1, wdog=0, state=GRANT.
  - Latency: exactly 1 cycle from a sampled req to grant.
- State GRANT:
  - grant is frozen. Changes on req, including the owner deasserting its request, have no effect.
  - wdog increments each cycle while done=0.
  - done=1: at the next edge grant=0, grant_vld=0, busy=0, ptr=(winner+1) mod N, state=IDLE.
  - TIMEOUT!=0 and wdog==TIMEOUT-1 with done=0: same release as done, plus timeout_err=1 for exactly one cycle.
  - done and timeout in the same cycle: done wins and timeout_err stays 0.
- Mandatory gap: at least one IDLE cycle with grant=0 between consecutive grants. The downstream encoder never sees two grant codes on adjacent cycles.
- done while in IDLE: ignored.
- Single persistent requester k: served every other cycle pair (grant, gap). ptr moves to k+1, but the wrap scan still finds k.
- Invariant, checked by assertion: $onehot0(grant) every cycle; grant_vld == |grant.
- Wrap: winner N-1 sets ptr=0.

Decomposition:
- Shared package arb_pkg holds:
  - localparam N_REQ=4 and IDX_W=$clog2(N_REQ);
  - typedef enum logic {IDLE, GRANT} arb_state_t;
  - typedef logic [N_REQ-1:0] req_vec_t.
  - The same package is shared with the encoder/decoder bench for width consistency.
- One sub-module, rr_pick:
  - purely combinational;
  - inputs req and ptr; outputs a one-hot pick and its index;
  - implemented as rotate-right by ptr, find-first-set, then rotate back.
- The FSM, ptr, watchdog and output registers stay in rr_onehot_arbiter.

Test Plan:
- Reset then req=4'b0000 for 5 cycles -> grant=0, grant_vld=0, busy=0 throughout.
- From reset, req=4'b1010 -> next cycle grant=4'b0010. done pulse -> grant=0 the following cycle. The cycle after that, grant=4'b1000, proving ptr advanced to 2.
- req=4'b1111 held, done asserted on every grant cycle:
  - grant sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001 (wrap).
  - Encoder output y follows 0, 1, 2, 3, 0.
- req=4'b0100 then dropped to 0 during GRANT, no done, TIMEOUT=16:
  - grant=4'b0100 held for 16 cycles, then grant=0 with timeout_err=1 for one cycle;
  - ptr=3 afterwards.
- done and the watchdog expiry coincide on the 16th cycle -> release occurs, timeout_err stays 0.
- rst_n asserted low mid-GRANT with grant=4'b1000 -> grant=0 asynchronously before the next edge. After release, req=4'b1000 is granted from ptr=0 scan, giving grant=4'b1000 after 1 cycle.
